// File: rtl/img_filter3x3_stream.sv
// Streaming 3x3 neighbourhood filter: two on-chip line buffers feed a 3x3 window,
// followed by a sum stage and a normalise/clamp stage on a valid/ready stream.
//
// state | meaning
// IDLE  | waiting for start; configuration sampled here
// RUN   | accepting W*H input pixels
// DRAIN | input closed, flushing pipeline until the m_last handshake
// DONE  | one-cycle done pulse
module img_filter3x3_stream #(
  parameter int PIX_W = 8,
  parameter int MAX_W = 640,
  parameter int W_W   = 10,
  parameter int H_W   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [W_W-1:0]   cfg_width,
  input  logic [H_W-1:0]   cfg_height,
  input  logic [1:0]       cfg_mode,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [PIX_W-1:0] m_data,
  output logic             m_last,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  localparam int SW = PIX_W + 6;
  localparam logic [W_W-1:0] MAX_W_V = W_W'(MAX_W);
  localparam logic signed [SW-1:0] PIX_MAX = SW'((1 << PIX_W) - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [W_W-1:0]   width_q, col;
  logic [H_W-1:0]   height_q, row;
  logic [1:0]       mode_q;
  logic             en, accept, cfg_ok, last_in, qualify, col_end;
  logic [PIX_W-1:0] lb0 [MAX_W];
  logic [PIX_W-1:0] lb1 [MAX_W];
  logic [PIX_W-1:0] lb0_rd, lb1_rd;
  logic [PIX_W-1:0] win [3][3];
  logic             v1, last1, v2, last2;
  logic signed [SW-1:0] c_s, n4_s, dg_s, sum1, sum2, mag;
  logic [PIX_W-1:0] res;

  function automatic logic signed [SW-1:0] ext(input logic [PIX_W-1:0] p);
    return signed'(SW'(p));
  endfunction

  assign cfg_ok  = (cfg_width >= W_W'(3)) && (cfg_width <= MAX_W_V) && (cfg_height >= H_W'(3));
  assign en      = !m_valid || m_ready;
  assign accept  = s_valid && s_ready;
  assign col_end = (col == width_q - W_W'(1));
  assign last_in = col_end && (row == height_q - H_W'(1));
  assign qualify = (row >= H_W'(2)) && (col >= W_W'(2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && cfg_ok) state_nxt = RUN;
      RUN:     if (accept && last_in) state_nxt = DRAIN;
      DRAIN:   if (m_valid && m_ready && m_last) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_ready = (state == RUN) && en;
    busy    = (state == RUN) || (state == DRAIN);
    done    = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err  <= 1'b0;
      width_q  <= '0;
      height_q <= '0;
      mode_q   <= '0;
      col      <= '0;
      row      <= '0;
    end else begin
      cfg_err <= (state == IDLE) && start && !cfg_ok;
      if ((state == IDLE) && start && cfg_ok) begin
        width_q  <= cfg_width;
        height_q <= cfg_height;
        mode_q   <= cfg_mode;
        col      <= '0;
        row      <= '0;
      end else if (accept) begin
        if (col_end) begin
          col <= '0;
          row <= row + H_W'(1);
        end else begin
          col <= col + W_W'(1);
        end
      end
    end
  end

  // Async read returns the pre-write value, giving read-old-data on the shift.
  assign lb0_rd = lb0[col];
  assign lb1_rd = lb1[col];

  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col] <= lb0_rd;
      lb0[col] <= s_data;
    end
  end

  always_comb begin
    c_s  = ext(win[1][1]);
    n4_s = ext(win[0][1]) + ext(win[2][1]) + ext(win[1][0]) + ext(win[1][2]);
    dg_s = ext(win[0][0]) + ext(win[0][2]) + ext(win[2][0]) + ext(win[2][2]);
    case (mode_q)
      2'd0:    sum1 = c_s;
      2'd1:    sum1 = dg_s + (n4_s <<< 1) + (c_s <<< 2);
      2'd2:    sum1 = (c_s <<< 2) + c_s - n4_s;
      default: sum1 = (c_s <<< 2) - n4_s;
    endcase
  end

  always_comb begin
    res = '0;
    mag = sum2[SW-1] ? -sum2 : sum2;
    case (mode_q)
      2'd0: res = PIX_W'(sum2);
      2'd1: res = PIX_W'(sum2 >>> 4);
      2'd2: begin
        if (sum2[SW-1])          res = '0;
        else if (sum2 > PIX_MAX) res = '1;
        else                     res = PIX_W'(sum2);
      end
      default: res = (mag > PIX_MAX) ? '1 : PIX_W'(mag);
    endcase
  end

  // Window shifts only on accepted pixels; later stages advance on every enabled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++)
        for (int k = 0; k < 3; k++)
          win[r][k] <= '0;
      v1      <= 1'b0;
      last1   <= 1'b0;
      v2      <= 1'b0;
      last2   <= 1'b0;
      sum2    <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_data  <= '0;
    end else begin
      if (accept) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= lb1_rd;
        win[1][2] <= lb0_rd;
        win[2][2] <= s_data;
      end
      if (en) begin
        v1      <= accept && qualify;
        last1   <= accept && last_in;
        v2      <= v1;
        last2   <= last1;
        sum2    <= sum1;
        m_valid <= v2;
        m_last  <= v2 && last2;
        if (v2) m_data <= res;
      end
    end
  end

endmodule
